// File: rtl/spi_sram_master_if.sv
// CPU-side memory port of the SPI SRAM bridge: request strobe, attributes, read data and status.
interface spi_sram_master_if #(
    parameter int ADDR_BITS = 24
);
    logic                 valid;
    logic                 memwrite;
    logic [1:0]           size;
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 busy;
    logic                 done;

    modport master (
        output valid, memwrite, size, addr, wdata,
        input  rdata, busy, done
    );

    modport slave (
        input  valid, memwrite, size, addr, wdata,
        output rdata, busy, done
    );
endinterface

// File: rtl/spi_sram_master.sv
// SPI mode-0 initiator for 23LC1024-class serial SRAM: READ/WRITE command, address,
// then 1/2/4 data bytes, lowest address first.
module spi_sram_master #(
    parameter int CLK_DIV   = 2,
    parameter int ADDR_BITS = 24,
    parameter int CE_GAP    = 2
) (
    input  logic                clk,
    input  logic                reset,
    spi_sram_master_if.slave    bus,
    output logic                sclk,
    output logic                sram_ce,
    output logic                si,
    input  logic                so
);
    localparam int TXW  = 8 + ADDR_BITS + 32;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAPW = $clog2(CE_GAP + 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, FINISH, GAP} state_t;

    state_t          state, next_phase;
    logic [DIVW-1:0] div_cnt;
    logic [5:0]      bit_cnt;
    logic [5:0]      data_bits;
    logic [5:0]      phase_len;
    logic [TXW-1:0]  tx_sr, tx_load;
    logic [31:0]     rx_sr, rx_word, wd_swap;
    logic [GAPW-1:0] gap_cnt;
    logic            is_write;
    logic            half_done, phase_last;

    // Data bytes go out byte0 first; unused trailing bytes are zeroed so si idles low.
    always_comb begin
        wd_swap = {bus.wdata[7:0], bus.wdata[15:8], bus.wdata[23:16], bus.wdata[31:24]};
        case (bus.size)
            2'b00:   wd_swap = wd_swap & 32'hFF00_0000;
            2'b01:   wd_swap = wd_swap & 32'hFFFF_0000;
            default: wd_swap = wd_swap;
        endcase
        if (!bus.memwrite) wd_swap = 32'h0;
        tx_load = {(bus.memwrite ? 8'h02 : 8'h03), bus.addr, wd_swap};
    end

    always_comb begin
        phase_len  = data_bits;
        next_phase = FINISH;
        case (state)
            CMD: begin
                phase_len  = 6'd8;
                next_phase = ADDR;
            end
            ADDR: begin
                phase_len  = 6'(ADDR_BITS);
                next_phase = is_write ? WDATA : RDATA;
            end
            default: ;
        endcase
    end

    assign half_done  = (div_cnt == DIVW'(CLK_DIV - 1));
    assign phase_last = (bit_cnt == phase_len - 6'd1);

    // First received byte sits highest in rx_sr; reorder so it lands in rdata[7:0].
    always_comb begin
        case (data_bits)
            6'd8:    rx_word = {24'h0, rx_sr[7:0]};
            6'd16:   rx_word = {16'h0, rx_sr[7:0], rx_sr[15:8]};
            default: rx_word = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sclk      <= 1'b0;
            sram_ce   <= 1'b1;
            si        <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.rdata <= 32'h0;
            gap_cnt   <= GAPW'(CE_GAP);
            div_cnt   <= '0;
            bit_cnt   <= '0;
            data_bits <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            is_write  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid && gap_cnt >= GAPW'(CE_GAP)) begin
                        is_write  <= bus.memwrite;
                        data_bits <= (bus.size == 2'b00) ? 6'd8 :
                                     (bus.size == 2'b01) ? 6'd16 : 6'd32;
                        si        <= tx_load[TXW-1];
                        tx_sr     <= {tx_load[TXW-2:0], 1'b0};
                        rx_sr     <= '0;
                        sram_ce   <= 1'b0;
                        sclk      <= 1'b0;
                        bus.busy  <= 1'b1;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= CMD;
                    end
                end
                CMD, ADDR, WDATA, RDATA: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            if (state == RDATA) rx_sr <= {rx_sr[30:0], so};
                        end else begin
                            // Falling edge: present the next bit a full half-period ahead.
                            sclk  <= 1'b0;
                            si    <= tx_sr[TXW-1];
                            tx_sr <= {tx_sr[TXW-2:0], 1'b0};
                            if (phase_last) begin
                                bit_cnt <= '0;
                                state   <= next_phase;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIVW'(1);
                    end
                end
                FINISH: begin
                    sclk     <= 1'b0;
                    si       <= 1'b0;
                    sram_ce  <= 1'b1;
                    bus.done <= 1'b1;
                    if (!is_write) bus.rdata <= rx_word;
                    gap_cnt  <= GAPW'(1);
                    state    <= GAP;
                end
                GAP: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    if (gap_cnt >= GAPW'(CE_GAP)) state <= IDLE;
                    else gap_cnt <= gap_cnt + GAPW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sram_master.sv
// Directed + random bench for spi_sram_master against a serial SRAM device model
// and a byte-array reference memory.
module tb_spi_sram_master;
    localparam int CLK_DIV = 2;
    localparam int AB      = 24;
    localparam int CE_GAP  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk, sram_ce, si;
    logic so = 1'b0;

    spi_sram_master_if #(.ADDR_BITS(AB)) bus();

    spi_sram_master #(.CLK_DIV(CLK_DIV), .ADDR_BITS(AB), .CE_GAP(CE_GAP)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .sclk(sclk), .sram_ce(sram_ce), .si(si), .so(so)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serial SRAM device model: sequential mode, 256-byte window of the address space.
    logic [7:0]  dev_mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  cap_q [$];
    logic [7:0]  sh, cmd;
    logic [23:0] daddr;
    int bitcnt = 0;
    int ce_falls = 0;
    int done_cnt = 0;
    int hi_run = 0;
    int min_gap = 1000;

    always @(negedge sram_ce) begin
        bitcnt = 0;
        cap_q.delete();
        ce_falls++;
        so = 1'b0;
    end

    always @(posedge sclk) begin
        if (sram_ce === 1'b0) begin
            sh = {sh[6:0], si};
            bitcnt++;
            if (bitcnt % 8 == 0) begin
                cap_q.push_back(sh);
                if (bitcnt == 8) cmd = sh;
                else if (bitcnt <= 32) daddr = {daddr[15:0], sh};
                else if (cmd == 8'h02) dev_mem[(int'(daddr) + (bitcnt - 40) / 8) & 255] = sh;
            end
        end
    end

    always @(negedge sclk) begin
        int idx;
        logic [7:0] b;
        if (sram_ce === 1'b0 && cmd == 8'h03 && bitcnt >= 32) begin
            idx = bitcnt - 32;
            b   = dev_mem[(int'(daddr) + idx / 8) & 255];
            so  = b[7 - idx % 8];
        end
    end

    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (sram_ce === 1'b1) hi_run++;
        else if (sram_ce === 1'b0 && hi_run > 0) begin
            if (hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
        end
    end

    logic [31:0] last_rd = 32'h0;

    task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [23:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd);
        bit acc = 0;
        bit got = 0;
        @(negedge clk);
        bus.valid = 1'b1; bus.memwrite = wr; bus.size = sz; bus.addr = a; bus.wdata = wd;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) acc = 1;
        end
        bus.valid = 1'b0;
        bus.addr  = ~a;
        bus.wdata = ~wd;
        chk("accept", 32'(acc), 32'd1);
        lat = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done === 1'b1) got = 1;
        end
        chk("done_seen", 32'(got), 32'd1);
        rd = bus.rdata;
    endtask

    task automatic check_txn(input bit wr, input logic [1:0] sz, input logic [23:0] a,
                             input logic [31:0] wd);
        int nb, lat;
        logic [31:0] rd, exp_rd;
        logic [7:0]  exp_q [$];
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_q = {(wr ? 8'h02 : 8'h03), a[23:16], a[15:8], a[7:0]};
        if (wr) for (int i = 0; i < nb; i++) exp_q.push_back(wd[8*i +: 8]);
        run_txn(wr, sz, a, wd, lat, rd);
        chk("latency", 32'(lat), 32'((32 + 8 * nb) * 2 * CLK_DIV + 1));
        chk("sclk_rises", 32'(bitcnt), 32'(32 + 8 * nb));
        chk("stream_len", 32'(cap_q.size()), 32'(4 + nb));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk($sformatf("si_byte%0d", i), 32'(cap_q[i]), 32'(exp_q[i]));
        chk("ce_high_at_done", 32'(sram_ce), 32'd1);
        chk("busy_at_done", 32'(bus.busy), 32'd1);
        if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[(int'(a) + i) & 255] = wd[8*i +: 8];
            chk("rdata_held", rd, last_rd);
        end else begin
            exp_rd = 32'h0;
            for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_mem[(int'(a) + i) & 255];
            chk("rdata", rd, exp_rd);
            last_rd = exp_rd;
        end
        @(posedge clk); #1;
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dc, cf;
        logic [7:0] b;
        bus.valid = 1'b0; bus.memwrite = 1'b0; bus.size = 2'b00;
        bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            dev_mem[i] = b;
            ref_mem[i] = b;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_ce", 32'(sram_ce), 32'd1);
        chk("rst_si", 32'(si), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        check_txn(1'b1, 2'b10, 24'h000010, 32'hDEADBEEF);
        check_txn(1'b0, 2'b10, 24'h000010, 32'h0);
        chk("word_read_value", last_rd, 32'hDEADBEEF);

        dev_mem[8'h40] = 8'hA5;
        ref_mem[8'h40] = 8'hA5;
        check_txn(1'b0, 2'b00, 24'h000040, 32'h0);
        chk("byte_read_value", last_rd, 32'h000000A5);

        check_txn(1'b1, 2'b01, 24'h000020, 32'h1234ABCD);
        check_txn(1'b0, 2'b10, 24'h000020, 32'h0);

        // Stray valid pulses while busy and in the post-done gap must not start transfers.
        dc = done_cnt;
        cf = ce_falls;
        fork
            check_txn(1'b1, 2'b10, 24'h000080, 32'h0BADF00D);
            begin
                repeat (60) @(negedge clk);
                bus.valid = 1'b1;
                @(negedge clk);
                bus.valid = 1'b0;
            end
        join
        @(negedge clk);
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (300) @(posedge clk);
        chk("ignored_done_count", 32'(done_cnt - dc), 32'd1);
        chk("ignored_ce_falls", 32'(ce_falls - cf), 32'd1);

        // Abort in the address phase.
        dc = done_cnt;
        @(negedge clk);
        bus.valid = 1'b1; bus.memwrite = 1'b1; bus.size = 2'b10;
        bus.addr = 24'h000090; bus.wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ce", 32'(sram_ce), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(posedge clk);
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        check_txn(1'b0, 2'b10, 24'h000090, 32'h0);

        for (int n = 0; n < 10; n++)
            check_txn(1'($urandom), 2'($urandom), 24'($urandom), $urandom);

        chk("ce_gap_min", 32'(min_gap >= CE_GAP), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
